// File: rtl/alu_if.sv
// Memory port of the Phaethon core: one outstanding read or write at a time.
// The core is the master; the external memory is the slave.
interface alu_if;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;

  modport master (
    input  ramValue, readAck, writeAck,
    output ramAddress, ramOut, readReq, writeReq
  );

  modport slave (
    output ramValue, readAck, writeAck,
    input  ramAddress, ramOut, readReq, writeReq
  );
endinterface

// File: rtl/alu.sv
// Phaethon execution block: fetch/exec/mem core with four 32-bit registers.
// ALU_DEBUG_EN adds a register holding the last written result on debug.
module alu (
  input  logic        clk,
  input  logic        reset,
  alu_if.master       bus,
  output logic [7:0]  iPointer,
  output logic [7:0]  opCode,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] debug
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

  state_t      state;
  logic [31:0] regs [4];
  logic [7:0]  ip;
  logic [31:0] ir;

  logic [7:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [31:0] imm;
  logic [31:0] mem_addr;
  logic        is_load;
  logic        is_store;
  logic [31:0] res;
  logic        wr_en;
  logic [7:0]  ip_next;
  logic        unused_ir_bits;

  assign op       = ir[7:0];
  assign rd       = ir[9:8];
  assign rs       = ir[13:12];
  assign imm      = {16'b0, ir[31:16]};
  assign mem_addr = regs[rs] + imm;
  assign is_load  = (op == 8'h0A);
  assign is_store = (op == 8'h0B);
  assign unused_ir_bits = ^{ir[15:14], ir[11:10]};

  always_comb begin
    res     = '0;
    wr_en   = 1'b0;
    ip_next = ip + 8'd4;
    case (op)
      8'h01: begin res = imm;                           wr_en = 1'b1; end
      8'h02: begin res = regs[rs];                      wr_en = 1'b1; end
      8'h03: begin res = regs[rd] + regs[rs];           wr_en = 1'b1; end
      8'h04: begin res = regs[rd] - regs[rs];           wr_en = 1'b1; end
      8'h05: begin res = regs[rd] & regs[rs];           wr_en = 1'b1; end
      8'h06: begin res = regs[rd] | regs[rs];           wr_en = 1'b1; end
      8'h07: begin res = regs[rd] ^ regs[rs];           wr_en = 1'b1; end
      8'h08: begin res = regs[rd] << regs[rs][4:0];     wr_en = 1'b1; end
      8'h09: begin res = regs[rd] >> regs[rs][4:0];     wr_en = 1'b1; end
      8'h0C: ip_next = imm[7:0];
      8'h0D: if (regs[rd] == 32'd0) ip_next = imm[7:0];
      8'h0E: if (regs[rd] != 32'd0) ip_next = imm[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ip    <= '0;
      ir    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.readAck) begin
            ir    <= bus.ramValue;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_load || is_store) begin
            state <= MEM;
          end else if (op == 8'hFF) begin
            state <= HALTED;
          end else begin
            if (wr_en) regs[rd] <= res;
            ip    <= ip_next;
            state <= FETCH;
          end
        end
        MEM: begin
          // Address and store data stay stable here until the ack edge.
          if (is_load && bus.readAck) begin
            regs[rd] <= bus.ramValue;
            ip       <= ip + 8'd4;
            state    <= FETCH;
          end else if (is_store && bus.writeAck) begin
            ip    <= ip + 8'd4;
            state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Requests drop combinationally in the ack cycle so memory never sees a repeat.
  assign bus.readReq    = ((state == FETCH) || (state == MEM && is_load)) && !bus.readAck;
  assign bus.writeReq   = (state == MEM) && is_store && !bus.writeAck;
  assign bus.ramAddress = (state == FETCH) ? {24'b0, ip} :
                          (state == MEM)   ? mem_addr    : 32'd0;
  assign bus.ramOut     = ((state == MEM) && is_store) ? regs[rd] : 32'd0;

  assign iPointer = ip;
  assign opCode   = op;
  assign r0       = regs[0];
  assign r1       = regs[1];

`ifdef ALU_DEBUG_EN
  logic [31:0] dbg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_q <= '0;
    end else if (state == EXEC && wr_en) begin
      dbg_q <= res;
    end else if (state == MEM && is_load && bus.readAck) begin
      dbg_q <= bus.ramValue;
    end
  end

  assign debug = dbg_q;
`else
  assign debug = '0;
`endif
endmodule

// File: tb/tb_alu.sv
// Directed bench for the alu core with a small latency memory model and a
// scoreboard of expected observations.
module tb_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  iPointer;
  logic [7:0]  opCode;
  logic [31:0] r0, r1, debug;

  alu_if bus ();

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.master),
    .iPointer (iPointer),
    .opCode   (opCode),
    .r0       (r0),
    .r1       (r1),
    .debug    (debug)
  );

  initial forever #5 clk = ~clk;

  logic [31:0] prog [64];
  logic [31:0] store_word = 32'd0;
  int          mem_cnt = 0;

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[8'h00 >> 2] = 32'h1234_0001; // MOVI r0,0x1234
    prog[8'h04 >> 2] = 32'h0002_0101; // MOVI r1,2
    prog[8'h08 >> 2] = 32'h0000_1003; // ADD r0,r1
    prog[8'h0C >> 2] = 32'h0010_0101; // MOVI r1,0x10
    prog[8'h10 >> 2] = 32'h0030_100B; // STORE r0,[r1+0x30]
    prog[8'h14 >> 2] = 32'h0030_110A; // LOAD r1,[r1+0x30]
    prog[8'h18 >> 2] = 32'h0000_0001; // MOVI r0,0
    prog[8'h1C >> 2] = 32'h0020_000D; // JZ r0,0x20
    prog[8'h20 >> 2] = 32'h0040_000E; // JNZ r0,0x40
    prog[8'h24 >> 2] = 32'h0001_0101; // MOVI r1,1
    prog[8'h28 >> 2] = 32'h0000_1004; // SUB r0,r1
    prog[8'h2C >> 2] = 32'h0021_0101; // MOVI r1,33
    prog[8'h30 >> 2] = 32'h0003_0001; // MOVI r0,3
    prog[8'h34 >> 2] = 32'h0000_1008; // SHL r0,r1
    prog[8'h38 >> 2] = 32'h0060_000C; // JMP 0x60
    prog[8'h60 >> 2] = 32'h0000_0055; // undefined -> NOP
    prog[8'h64 >> 2] = 32'h0000_00FF; // HALT
  end

  // Memory acks on the second edge that sees a request; word 0x40 is the data word.
  always @(posedge clk) begin
    bus.readAck  <= 1'b0;
    bus.writeAck <= 1'b0;
    if (reset || stall) begin
      mem_cnt <= 0;
    end else if ((bus.readReq || bus.writeReq) && !bus.readAck && !bus.writeAck) begin
      if (mem_cnt == 1) begin
        mem_cnt <= 0;
        if (bus.readReq) begin
          bus.readAck  <= 1'b1;
          bus.ramValue <= (bus.ramAddress == 32'h40) ? store_word : prog[bus.ramAddress[7:2]];
        end else begin
          bus.writeAck <= 1'b1;
          if (bus.ramAddress == 32'h40) store_word <= bus.ramOut;
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  int          checks = 0;
  int          errors = 0;
  string       sb_tag [$];
  logic [31:0] sb_val [$];

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp_v;
    tag   = sb_tag.pop_front();
    exp_v = sb_val.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  function automatic bit cond(input int kind, input logic [31:0] v);
    case (kind)
      0: return iPointer == v[7:0];
      1: return bus.writeReq === 1'b1;
      2: return opCode == v[7:0];
      default: return (bus.readReq === 1'b1) && (bus.ramAddress == v);
    endcase
  endfunction

  // Bounded wait at negedges; expiry counts as a failed check.
  task automatic wait_for(input string tag, input int kind, input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = cond(kind, v);
    end
    expect_val({tag, "_reached"}, 32'd1);
    check({31'd0, ok});
  endtask

  function automatic logic [31:0] dbg_exp(input logic [31:0] v);
`ifdef ALU_DEBUG_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    int busy;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    expect_val("rst_readReq", 32'd1);     check({31'd0, bus.readReq});
    expect_val("rst_ramAddress", 32'd0);  check(bus.ramAddress);
    expect_val("rst_iPointer", 32'd0);    check(32'(iPointer));
    expect_val("rst_opCode", 32'd0);      check(32'(opCode));
    expect_val("rst_r0", 32'd0);          check(r0);
    expect_val("rst_r1", 32'd0);          check(r1);
    expect_val("rst_debug", 32'd0);       check(debug);

    wait_for("add_ip", 0, 32'h0C);
    expect_val("add_r0", 32'h0000_1236);  check(r0);
    expect_val("add_r1", 32'h0000_0002);  check(r1);
    expect_val("add_debug", dbg_exp(32'h0000_1236)); check(debug);

    wait_for("store_req", 1, 32'd0);
    expect_val("store_addr", 32'h40);     check(bus.ramAddress);
    expect_val("store_data", 32'h1236);   check(bus.ramOut);
    expect_val("store_noread", 32'd0);    check({31'd0, bus.readReq});

    wait_for("load_ip", 0, 32'h18);
    expect_val("load_r1", 32'h1236);      check(r1);
    expect_val("load_debug", dbg_exp(32'h1236)); check(debug);

    wait_for("jz_ip", 0, 32'h20);
    wait_for("jnz_ip", 0, 32'h24);
    wait_for("sub_ip", 0, 32'h2C);
    expect_val("sub_r0", 32'hFFFF_FFFF);  check(r0);
    wait_for("shl_ip", 0, 32'h38);
    expect_val("shl_r0", 32'h0000_0006);  check(r0);
    wait_for("jmp_ip", 0, 32'h60);
    wait_for("halt_op", 2, 32'hFF);

    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.readReq || bus.writeReq) busy++;
    end
    expect_val("halt_quiet", 32'd0);      check(32'(busy));
    expect_val("halt_ip", 32'h64);        check(32'(iPointer));
    expect_val("halt_r0", 32'h6);         check(r0);
    expect_val("halt_r1", 32'd33);        check(r1);
    expect_val("halt_debug", dbg_exp(32'h6)); check(debug);

    // Rerun from reset and abort the core while it waits on the load.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_for("load_wait", 3, 32'h40);
    stall = 1'b1;
    repeat (4) @(negedge clk);
    expect_val("stall_readReq", 32'd1);   check({31'd0, bus.readReq});
    expect_val("stall_ip", 32'h14);       check(32'(iPointer));
    reset = 1'b1;
    #1;
    expect_val("abort_readReq", 32'd1);   check({31'd0, bus.readReq});
    expect_val("abort_addr", 32'd0);      check(bus.ramAddress);
    expect_val("abort_ip", 32'd0);        check(32'(iPointer));
    expect_val("abort_r0", 32'd0);        check(r0);
    expect_val("abort_opCode", 32'd0);    check(32'(opCode));
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    wait_for("rerun_ip", 0, 32'h0C);
    expect_val("rerun_r0", 32'h1236);     check(r0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Single-issue 32-bit processor core, the Phaethon execution block, despite its historical ALU name. It fetches 32-bit instruction words from an external byte-addressed memory over a request/acknowledge port. It executes register arithmetic, loads, stores and branches on four 32-bit registers, and exposes its instruction pointer, opcode, r0/r1 and a debug word for observation. Memory is an external block that answers one request at a time.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ramValue  in  32  read data, little-endian word at the requested address; valid while readAck=1.
- readAck  in  1  read complete; level, high for exactly the cycle data is valid.
- writeAck  in  1  write complete.
- ramAddress  out  32  byte address for current request.
- ramOut  out  32  write data; valid while writeReq=1.
- readReq  out  1  read request.
- writeReq  out  1  write request.
- iPointer  out  8  address of the current instruction.
- opCode  out  8  byte 0 of the current instruction.
- r0, r1  out  32  architectural registers 0 and 1.
- debug  out  32  see Configuration.

## Operation
- Registers r0..r3: 32 bits each; ip: 8 bits; instruction register ir: 32 bits.
- Encoding: ir[7:0]=op, ir[9:8]=rd, ir[13:12]=rs, ir[31:16]=imm16, zero-extended to 32 bits. Unused bits are ignored.
- Ops: 00 NOP; 01 MOVI rd=imm; 02 MOV rd=rs; 03 ADD rd=rd+rs; 04 SUB rd=rd-rs; 05 AND; 06 OR; 07 XOR; 08 SHL rd=rd<<rs[4:0]; 09 SHR (logical) rd=rd>>rs[4:0]; 0A LOAD rd=mem[rs+imm]; 0B STORE mem[rs+imm]=rd; 0C JMP ip=imm[7:0]; 0D JZ if rd==0 ip=imm[7:0]; 0E JNZ if rd!=0 ip=imm[7:0]; FF HALT.
- Undefined opcodes execute as NOP.
- Arithmetic is mod 2^32 with no flags. Load/store address is rs+imm mod 2^32.
- Non-taken and non-jump instructions advance ip by 4, mod 256; ip wraps 0xFC->0x00. ip need not be word-aligned.
- States:
  - FETCH: ramAddress={24'b0,ip}; on readAck, ir<=ramValue and go to EXEC.
  - EXEC: apply the op. LOAD/STORE go to MEM; HALT goes to HALTED; everything else goes to FETCH.
  - MEM: ramAddress=rs+imm. LOAD: on readAck, rd<=ramValue, ip+=4, go to FETCH. STORE: ramOut=rd, on writeAck, ip+=4, go to FETCH.
  - HALTED: terminal; only reset leaves it.
- opCode tracks ir[7:0]. iPointer tracks ip.

## Timing
- Reset (asynchronous): r0..r3=0, ip=0, ir=0, state=FETCH. Outputs are therefore opCode=0, iPointer=0, debug=0, and ramAddress=0 with readReq asserted in FETCH.
- Reset asserted mid-transaction aborts it. Any late ack arriving after reset releases is consumed only if the core is then waiting in FETCH.
- readReq = (state==FETCH or LOAD in MEM) && !readAck.
- writeReq = (STORE in MEM) && !writeAck.
- Requests are combinationally dropped in the ack cycle, so the memory never sees a duplicate request. ramAddress and ramOut are held stable for the whole request.
- Acks outside a waiting state are ignored. Never assert readReq and writeReq together.
- With a memory that acks 2 cycles after sampling the request:
  - ALU/jump instruction: 3 cycles (2 wait cycles + EXEC).
  - LOAD/STORE: 5 cycles.
- Register writes and ip update happen at the EXEC edge, or at the ack edge for LOAD/STORE.

## Configuration
- ALU_DEBUG_EN defined: debug holds the last 32-bit result written to any register by an EXEC or LOAD, reset to 0.
- ALU_DEBUG_EN undefined: debug is tied to 0 and the holding register is removed.

## Test plan
- Reset release -> readReq=1, ramAddress=0, iPointer=0, opCode=0, r0=r1=0.
- Program: MOVI r0,0x1234; MOVI r1,0x0002; ADD r0,r1 -> r0=0x00001236, r1=2, iPointer=0x0C.
- MOVI r1,0x0010; STORE r0,[r1+0x30]; LOAD r1,[r1+0x30] -> writeReq with ramAddress=0x40, ramOut=r0; afterwards r1=r0.
- MOVI r0,0; JZ r0,0x20 -> iPointer=0x20. JNZ r0,0x40 with r0=0 -> iPointer=old+4.
- SUB r0,r1 with r0=0, r1=1 -> r0=0xFFFFFFFF. SHL by rs=33 -> shift by 1.
- HALT at 0x64 -> no further readReq or writeReq, registers frozen. Reset during a LOAD wait -> state returns to FETCH at ip=0.
